regfile_bist_ctrl: RTL and testbench

- Initiator-side controller for the 4-entry, 32-bit register file: owns its write port (RegWrite / WriteReg / WriteData) and both read ports (ReadReg1/ReadReg2 -> ReadData1/ReadData2).
- On `start`, writes a deterministic pattern to every entry, reads every entry back through both read ports, compares the results and reports pass/fail.
- Used for power-on self-test of the register file and as a reusable traffic generator for it.

---
 rtl/regfile_bist_ctrl_if.sv | 24 ++
 rtl/regfile_bist_ctrl.sv | 155 +++++++++++++++
 tb/tb_regfile_bist_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_bist_ctrl_if.sv
// Register-file port bundle: one write port and two combinational read ports.
// The BIST controller drives it as master; the register file is the slave.
interface regfile_bist_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 2
);
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;

  modport master (
    output rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2
  );

  modport slave (
    input  rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2
  );
endinterface

// File: rtl/regfile_bist_ctrl.sv
// Register-file self-test: writes P(i)=SEED+i*STEP, reads back on both ports, reports pass/fail.
// Define RF_BIST_INVERT_EN to append an inverted-pattern write/read pass before DONE.
module regfile_bist_ctrl #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 2,
  parameter int unsigned       NUM_REGS = 4,
  parameter logic [DATA_W-1:0] SEED     = DATA_W'(32'hAAAAFFFF),
  parameter logic [DATA_W-1:0] STEP     = DATA_W'(32'h11111111)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [7:0]          err_cnt,
  regfile_bist_ctrl_if.master rf
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
`ifdef RF_BIST_INVERT_EN
    WRITE_INV,
    READ_INV,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [ADDR_W-1:0] idx_rev;
  logic [DATA_W-1:0] inv_mask;
  logic              checking;
  logic              mis1;
  logic              mis2;
  logic [8:0]        cnt_sum;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] i);
    return SEED + DATA_W'(i) * STEP;
  endfunction

  // Read addresses are registered copies of idx, so the compare uses idx directly.
  always_comb begin
    idx_nxt  = idx + 1'b1;
    idx_rev  = LAST - idx;
    inv_mask = '0;
    checking = (state == READ);
`ifdef RF_BIST_INVERT_EN
    if (state == READ_INV) begin
      inv_mask = '1;
      checking = 1'b1;
    end
`endif
    mis1    = rf.rf_rdata1 != (pat(idx) ^ inv_mask);
    mis2    = rf.rf_rdata2 != (pat(idx_rev) ^ inv_mask);
    cnt_sum = {1'b0, err_cnt} + 9'(mis1) + 9'(mis2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b1;
      err_addr     <= '0;
      err_cnt      <= '0;
      rf.rf_we     <= 1'b0;
      rf.rf_waddr  <= '0;
      rf.rf_wdata  <= '0;
      rf.rf_raddr1 <= '0;
      rf.rf_raddr2 <= '0;
    end else begin
      done <= 1'b0;
      if (checking) begin
        err_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        if (pass && (mis1 || mis2)) begin
          pass     <= 1'b0;
          err_addr <= mis1 ? idx : idx_rev;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state       <= WRITE;
            idx         <= '0;
            busy        <= 1'b1;
            pass        <= 1'b1;
            err_addr    <= '0;
            err_cnt     <= '0;
            rf.rf_we    <= 1'b1;
            rf.rf_waddr <= '0;
            rf.rf_wdata <= pat('0);
          end
        end
`ifdef RF_BIST_INVERT_EN
        WRITE, WRITE_INV: begin
`else
        WRITE: begin
`endif
          if (idx == LAST) begin
            state        <= (state == WRITE) ? READ : state_t'(state + 3'd1);
            idx          <= '0;
            rf.rf_we     <= 1'b0;
            rf.rf_raddr1 <= '0;
            rf.rf_raddr2 <= LAST;
          end else begin
            idx         <= idx_nxt;
            rf.rf_waddr <= idx_nxt;
            rf.rf_wdata <= pat(idx_nxt) ^ ((state == WRITE) ? '0 : '1);
          end
        end
`ifdef RF_BIST_INVERT_EN
        READ, READ_INV: begin
`else
        READ: begin
`endif
          if (idx == LAST) begin
            idx <= '0;
`ifdef RF_BIST_INVERT_EN
            if (state == READ) begin
              state       <= WRITE_INV;
              rf.rf_we    <= 1'b1;
              rf.rf_waddr <= '0;
              rf.rf_wdata <= ~pat('0);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            idx          <= idx_nxt;
            rf.rf_raddr1 <= idx_nxt;
            rf.rf_raddr2 <= LAST - idx_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Directed bench for regfile_bist_ctrl: two DUTs (default and wrapping pattern) each
// driving a behavioural register file; the default one can have entry 2 bit 0 stuck at 0.
module tb_regfile_bist_ctrl;

`ifdef RF_BIST_INVERT_EN
  localparam int INV = 1;
`else
  localparam int INV = 0;
`endif
  localparam int LAT = INV ? 17 : 9;
  localparam int NW  = INV ? 8 : 4;

  logic [31:0] pat_a [8] = '{32'hAAAAFFFF, 32'hBBBC1110, 32'hCCCD2221, 32'hDDDE3332,
                             32'h55550000, 32'h4443EEEF, 32'h3332DDDE, 32'h2221CCCD};
  logic [31:0] pat_b [8] = '{32'hFFFFFFF0, 32'hFFFFFFF8, 32'h00000000, 32'h00000008,
                             32'h0000000F, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFF7};

  logic clk, reset, start_a, start_b, stuck;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [1:0] err_addr_a, err_addr_b;
  logic [7:0] err_cnt_a, err_cnt_b;
  logic [31:0] mem_a [4];
  logic [31:0] mem_b [4];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cyc, busy_cnt, nw;
  logic [31:0] wlog [8];
  logic [1:0]  walog [8];

  regfile_bist_ctrl_if #(.DATA_W(32), .ADDR_W(2)) rf_a ();
  regfile_bist_ctrl_if #(.DATA_W(32), .ADDR_W(2)) rf_b ();

  regfile_bist_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_addr(err_addr_a), .err_cnt(err_cnt_a), .rf(rf_a)
  );

  regfile_bist_ctrl #(.SEED(32'hFFFFFFF0), .STEP(32'h00000008)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_addr(err_addr_b), .err_cnt(err_cnt_b), .rf(rf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_a.rf_we) mem_a[rf_a.rf_waddr] <= rf_a.rf_wdata;
    if (rf_b.rf_we) mem_b[rf_b.rf_waddr] <= rf_b.rf_wdata;
  end

  always_comb begin
    rf_a.rf_rdata1 = mem_a[rf_a.rf_raddr1];
    rf_a.rf_rdata2 = mem_a[rf_a.rf_raddr2];
    if (stuck && rf_a.rf_raddr1 == 2'd2) rf_a.rf_rdata1[0] = 1'b0;
    if (stuck && rf_a.rf_raddr2 == 2'd2) rf_a.rf_rdata2[0] = 1'b0;
    rf_b.rf_rdata1 = mem_b[rf_b.rf_raddr1];
    rf_b.rf_rdata2 = mem_b[rf_b.rf_raddr2];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulses start on one DUT and logs writes, busy cycles and the done cycle (-1 on timeout).
  task automatic run_seq(input bit use_b);
    logic we, dn, bz;
    logic [31:0] wd;
    logic [1:0] wa;
    done_cyc = -1;
    busy_cnt = 0;
    nw       = 0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      we = use_b ? rf_b.rf_we    : rf_a.rf_we;
      wd = use_b ? rf_b.rf_wdata : rf_a.rf_wdata;
      wa = use_b ? rf_b.rf_waddr : rf_a.rf_waddr;
      dn = use_b ? done_b : done_a;
      bz = use_b ? busy_b : busy_a;
      if (bz) busy_cnt++;
      if (we && nw < 8) begin
        wlog[nw]  = wd;
        walog[nw] = wa;
        nw++;
      end
      if (dn) begin
        done_cyc = c;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL reset_pass: got %b want 1", pass_a); end
    n_tests++; if (err_cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_a); end
    n_tests++; if (err_addr_a !== 2'd0) begin n_fail++; $display("FAIL reset_err_addr: got %0d want 0", err_addr_a); end
    n_tests++; if (rf_a.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_a.rf_we); end
    n_tests++;
    if ({rf_a.rf_raddr1, rf_a.rf_raddr2, rf_a.rf_waddr, rf_a.rf_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h/%h/%h want 0", rf_a.rf_raddr1,
                         rf_a.rf_raddr2, rf_a.rf_waddr, rf_a.rf_wdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_run;
    stuck = 1'b0;
    run_seq(1'b0);
    n_tests++; if (done_cyc != LAT) begin n_fail++; $display("FAIL clean_done_cycle: got %0d want %0d", done_cyc, LAT); end
    n_tests++; if (busy_cnt != LAT) begin n_fail++; $display("FAIL clean_busy_cycles: got %0d want %0d", busy_cnt, LAT); end
    n_tests++; if (nw != NW) begin n_fail++; $display("FAIL clean_write_count: got %0d want %0d", nw, NW); end
    for (int i = 0; i < NW; i++) begin
      n_tests++;
      if (wlog[i] !== pat_a[i] || walog[i] !== 2'(i)) begin
        n_fail++; $display("FAIL clean_write%0d: got %0d:%h want %0d:%h", i, walog[i], wlog[i], i % 4, pat_a[i]);
      end
    end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b want 1", pass_a); end
    n_tests++; if (err_cnt_a !== 8'd0) begin n_fail++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt_a); end
  endtask

  task automatic test_stuck_bit;
    stuck = 1'b1;
    run_seq(1'b0);
    n_tests++; if (done_cyc != LAT) begin n_fail++; $display("FAIL stuck_done_cycle: got %0d want %0d", done_cyc, LAT); end
    n_tests++; if (pass_a !== 1'b0) begin n_fail++; $display("FAIL stuck_pass: got %b want 0", pass_a); end
    n_tests++; if (err_addr_a !== 2'd2) begin n_fail++; $display("FAIL stuck_err_addr: got %0d want 2", err_addr_a); end
    n_tests++; if (err_cnt_a !== 8'd2) begin n_fail++; $display("FAIL stuck_err_cnt: got %0d want 2", err_cnt_a); end
    tick();
    tick();
    n_tests++; if (err_cnt_a !== 8'd2 || pass_a !== 1'b0) begin n_fail++; $display("FAIL stuck_hold: got cnt %0d pass %b want 2 0", err_cnt_a, pass_a); end
    stuck = 1'b0;
  endtask

  task automatic test_start_ignored;
    int ndone, first;
    ndone = 0;
    first = -1;
    start_a = 1'b1;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      tick();
      start_a = (c == 3);
      if (done_a) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    start_a = 1'b0;
    n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d want 1", ndone); end
    n_tests++; if (first != LAT) begin n_fail++; $display("FAIL ignored_done_cycle: got %0d want %0d", first, LAT); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ignored_idle_after: got %b want 0", busy_a); end
  endtask

  task automatic test_reset_mid;
    stuck = 1'b1;
    start_a = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start_a = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stuck = 1'b0;
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
    n_tests++; if (rf_a.rf_we !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b want 0", rf_a.rf_we); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL midreset_pass: got %b want 1", pass_a); end
    n_tests++; if (err_cnt_a !== 8'd0) begin n_fail++; $display("FAIL midreset_err_cnt: got %0d want 0", err_cnt_a); end
    run_seq(1'b0);
    n_tests++; if (done_cyc != LAT) begin n_fail++; $display("FAIL midreset_rerun_done: got %0d want %0d", done_cyc, LAT); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL midreset_rerun_pass: got %b want 1", pass_a); end
  endtask

  task automatic test_wrap;
    run_seq(1'b1);
    n_tests++; if (done_cyc != LAT) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want %0d", done_cyc, LAT); end
    n_tests++; if (nw != NW) begin n_fail++; $display("FAIL wrap_write_count: got %0d want %0d", nw, NW); end
    for (int i = 0; i < NW; i++) begin
      n_tests++;
      if (wlog[i] !== pat_b[i]) begin
        n_fail++; $display("FAIL wrap_write%0d: got %h want %h", i, wlog[i], pat_b[i]);
      end
    end
    n_tests++; if (pass_b !== 1'b1) begin n_fail++; $display("FAIL wrap_pass: got %b want 1", pass_b); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, c;
    d1 = -1;
    d2 = -1;
    start_a = 1'b1;
    for (c = 1; c <= 3 * LAT; c++) begin
      tick();
      if (done_a) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (d2 >= 0) break;
    end
    start_a = 1'b0;
    n_tests++; if (d1 != LAT) begin n_fail++; $display("FAIL b2b_first_done: got %0d want %0d", d1, LAT); end
    n_tests++; if (d2 != 2 * LAT + 1) begin n_fail++; $display("FAIL b2b_second_done: got %0d want %0d", d2, 2 * LAT + 1); end
    c = 0;
    while (busy_a && c < 40) begin
      tick();
      c++;
    end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got busy %b want 0", busy_a); end
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    stuck   = 1'b0;
    test_reset();
    test_clean_run();
    test_stuck_bit();
    test_start_ignored();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
